// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: the transmit
// sequencer state encoding, the odd-parity helper and the default
// parameter values used by ps2_tx_queue and ps2_clk_filter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAITR,
        RTS,
        START,
        DATA,
        STOP,
        ACK
    } state_t;

    localparam int DEF_DEPTH          = 4;
    localparam int DEF_RTS_CYCLES     = 8192;
    localparam int DEF_FILTER_LEN     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 131072;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Glitch filter for the PS/2 clock line. The raw line is synchronised,
// then the filtered level only changes after FILTER_LEN identical
// consecutive samples. fall_edge is a one-cycle pulse on a filtered 1->0.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c_in,
    output logic filtered,
    output logic fall_edge
);

    logic [1:0]            r_sync;
    logic [FILTER_LEN-1:0] r_hist;
    logic                  r_filt;
    logic                  r_fall;

    // Synchronise the line, keep a sample history and decide the settled level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_hist <= '0;
            r_filt <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], ps2c_in};
            r_hist <= {r_hist[FILTER_LEN-2:0], r_sync[1]};
            r_fall <= 1'b0;
            if (&r_hist) begin
                r_filt <= 1'b1;
            end else if (~|r_hist) begin
                r_filt <= 1'b0;
                r_fall <= r_filt;
            end
        end
    end

    assign filtered  = r_filt;
    assign fall_edge = r_fall;

endmodule

// File: rtl/ps2_tx_queue.sv
// PS/2 host-to-device transmitter with a small command FIFO.
// Bytes written into the FIFO are sent one at a time: wait for the
// receiver to go idle, request-to-send by holding the clock low, then
// shift out start, 8 data bits (LSB first), odd parity and stop, clocked
// by the device, and finally sample the device's ACK bit.
// Optional build macro PS2_TX_TIMEOUT_EN adds a watchdog that abandons a
// transfer if the device has not completed it within TIMEOUT_CYCLES of
// entering START; without it timeout_err is constant 0.
module ps2_tx_queue
    import ps2_pkg::*;
#(
    parameter int DEPTH          = DEF_DEPTH,
    parameter int RTS_CYCLES     = DEF_RTS_CYCLES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_ps2,
    input  logic [7:0]               din,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     rx_idle,
    input  logic                     ps2c_in,
    input  logic                     ps2d_in,
    output logic                     ps2c_oe,
    output logic                     ps2d_oe,
    output logic                     tx_idle,
    output logic                     tx_done_tick,
    output logic                     ack_err,
    output logic                     timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(RTS_CYCLES + 1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    state_t        r_state;
    logic [8:0]    r_shift;
    logic [3:0]    r_bits;
    logic [RW-1:0] r_rts;
    logic [1:0]    r_d_sync;
    logic          r_c_oe;
    logic          r_d_oe;
    logic          r_idle;
    logic          r_done;
    logic          r_aerr;

    logic          w_filt;
    logic          w_fall_raw;
    logic          w_fall;
    logic          w_tmo_fire;

    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = wr_ps2 & ~w_full;
    assign w_pop   = (r_state == IDLE) & ~w_empty;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c_in   (ps2c_in),
        .filtered  (w_filt),
        .fall_edge (w_fall_raw)
    );

    // A falling edge only counts once the filtered line has settled low.
    assign w_fall = w_fall_raw & ~w_filt;

    // FIFO storage holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

    // FIFO pointers and occupancy; full is judged before any same-cycle pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Two-flop synchroniser for the data line; the idle line reads high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_d_sync <= 2'b11;
        else       r_d_sync <= {r_d_sync[0], ps2d_in};
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;
    logic          r_terr;
    logic          w_active;

    assign w_active   = (r_state == START) || (r_state == DATA) ||
                        (r_state == STOP)  || (r_state == ACK);
    // A completing ACK edge in the final cycle still wins over the watchdog.
    assign w_tmo_fire = w_active && (r_tmo == TW'(TIMEOUT_CYCLES - 1)) &&
                        !((r_state == ACK) && w_fall);

    // Watchdog: counts cycles spent waiting on the device, restarting at START entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo  <= '0;
            r_terr <= 1'b0;
        end else begin
            r_terr <= w_tmo_fire;
            if (!w_active) r_tmo <= '0;
            else           r_tmo <= r_tmo + 1'b1;
        end
    end

    assign timeout_err = r_terr;
`else
    assign w_tmo_fire  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Transmit sequencer with registered line drivers and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bits  <= '0;
            r_rts   <= '0;
            r_c_oe  <= 1'b0;
            r_d_oe  <= 1'b0;
            r_idle  <= 1'b1;
            r_done  <= 1'b0;
            r_aerr  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_aerr <= 1'b0;
            if (w_tmo_fire) begin
                r_c_oe  <= 1'b0;
                r_d_oe  <= 1'b0;
                r_idle  <= 1'b1;
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!w_empty) begin
                            r_shift <= {odd_parity(r_mem[r_rptr]), r_mem[r_rptr]};
                            r_idle  <= 1'b0;
                            r_state <= WAITR;
                        end
                    end
                    WAITR: begin
                        if (rx_idle) begin
                            r_rts   <= RW'(RTS_CYCLES - 1);
                            r_c_oe  <= 1'b1;
                            r_state <= RTS;
                        end
                    end
                    RTS: begin
                        if (r_rts == '0) begin
                            r_c_oe  <= 1'b0;
                            r_d_oe  <= 1'b1;
                            r_state <= START;
                        end else begin
                            r_rts <= r_rts - 1'b1;
                        end
                    end
                    START: begin
                        if (w_fall) begin
                            r_bits  <= 4'd8;
                            r_d_oe  <= ~r_shift[0];
                            r_state <= DATA;
                        end
                    end
                    DATA: begin
                        if (w_fall) begin
                            if (r_bits == 4'd0) begin
                                r_d_oe  <= 1'b0;
                                r_state <= STOP;
                            end else begin
                                r_shift <= {1'b0, r_shift[8:1]};
                                r_d_oe  <= ~r_shift[1];
                                r_bits  <= r_bits - 1'b1;
                            end
                        end
                    end
                    STOP: begin
                        if (w_fall) r_state <= ACK;
                    end
                    ACK: begin
                        if (w_fall) begin
                            r_done  <= 1'b1;
                            r_aerr  <= r_d_sync[1];
                            r_idle  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign full         = w_full;
    assign level        = r_level;
    assign ps2c_oe      = r_c_oe;
    assign ps2d_oe      = r_d_oe;
    assign tx_idle      = r_idle;
    assign tx_done_tick = r_done;
    assign ack_err      = r_aerr;

endmodule

// File: tb/tb_ps2_tx_queue.sv
// Directed bench for ps2_tx_queue with an open-drain PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_tx_queue;

    localparam int DEPTH = 4;
    localparam int RTS   = 16;
    localparam int FLEN  = 8;
    localparam int TMO   = 200;
    localparam int H     = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    logic       full;
    logic [2:0] level;
    logic       rx_idle;
    logic       r_devc;
    logic       r_devd;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       ack_err;
    logic       timeout_err;
    wire        ps2c_line = r_devc & ~ps2c_oe;
    wire        ps2d_line = r_devd & ~ps2d_oe;

    always #5 clk = ~clk;

    ps2_tx_queue #(
        .DEPTH          (DEPTH),
        .RTS_CYCLES     (RTS),
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .full         (full),
        .level        (level),
        .rx_idle      (rx_idle),
        .ps2c_in      (ps2c_line),
        .ps2d_in      (ps2d_line),
        .ps2c_oe      (ps2c_oe),
        .ps2d_oe      (ps2d_oe),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .ack_err      (ack_err),
        .timeout_err  (timeout_err)
    );

    int total = 0;
    int bad   = 0;

    // Pulse and line monitors
    int   n_done = 0, n_err = 0, n_tmo = 0, n_both = 0, n_long = 0;
    logic p_done = 1'b0, p_err = 1'b0, p_tmo = 1'b0;
    always @(negedge clk) begin
        if (tx_done_tick) n_done <= n_done + 1;
        if (ack_err)      n_err  <= n_err + 1;
        if (timeout_err)  n_tmo  <= n_tmo + 1;
        if (ps2c_oe && ps2d_oe) n_both <= n_both + 1;
        if ((tx_done_tick && p_done) || (ack_err && p_err) || (timeout_err && p_tmo))
            n_long <= n_long + 1;
        p_done <= tx_done_tick;
        p_err  <= ack_err;
        p_tmo  <= timeout_err;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        wr_ps2 = 1'b1;
        din    = b;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    // Wait for START (start bit driven, clock released), then clock nfall falling edges.
    task automatic dev_xfer(input logic ack, input int nfall, output logic [8:0] cap, output logic ok);
        int w;
        cap = '0;
        ok  = 1'b1;
        w   = 0;
        while (!(ps2d_oe && !ps2c_oe) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) begin
            ok = 1'b0;
            return;
        end
        repeat (H) @(negedge clk);
        for (int k = 1; k <= nfall; k++) begin
            if (k == 12) r_devd = ack;
            r_devc = 1'b0;
            repeat (H - 2) @(negedge clk);
            if (k <= 9) cap[k-1] = ps2d_line;
            repeat (2) @(negedge clk);
            r_devc = 1'b1;
            repeat (H) @(negedge clk);
            r_devd = 1'b1;
        end
    endtask

    typedef struct {
        logic [7:0] b;
        logic       ack;
        logic       par;
        logic       err;
    } vec_t;

    vec_t       vecs[5];
    logic [8:0] cap;
    logic       ok;
    int         d0, e0, lat, cnt, w;

    initial begin
        vecs[0] = '{8'h55, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{8'h01, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'hF4, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0};

        reset = 1'b1; wr_ps2 = 1'b0; din = '0; rx_idle = 1'b1;
        r_devc = 1'b1; r_devd = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_tx_idle", tx_idle, 1);
        chk("rst_oe", {ps2c_oe, ps2d_oe}, 0);
        chk("rst_pulses", {tx_done_tick, ack_err, timeout_err}, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Table-driven transfers
        for (int i = 0; i < 5; i++) begin
            d0 = n_done;
            e0 = n_err;
            put(vecs[i].b);
            lat = 1;
            while (!ps2c_oe && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk("latency", lat, 3);
            dev_xfer(vecs[i].ack, 12, cap, ok);
            chk("xfer_start", ok, 1);
            repeat (5) @(negedge clk);
            chk("data_bits", cap[7:0], vecs[i].b);
            chk("parity", cap[8], vecs[i].par);
            chk("done_cnt", n_done - d0, 1);
            chk("ackerr_cnt", n_err - e0, vecs[i].err);
            chk("idle_after", tx_idle, 1);
        end

        // Hold in WAITR while the receiver is busy, then count RTS cycles
        rx_idle = 1'b0;
        put(8'hF4);
        repeat (40) @(negedge clk);
        chk("waitr_c_oe", ps2c_oe, 0);
        chk("waitr_tx_idle", tx_idle, 0);
        rx_idle = 1'b1;
        w = 0;
        while (!ps2c_oe && w < 10) begin
            @(negedge clk);
            w++;
        end
        cnt = 0;
        while (ps2c_oe && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("rts_len", cnt, RTS);
        dev_xfer(1'b0, 12, cap, ok);
        chk("waitr_data", {ok, cap}, {1'b1, 1'b0, 8'hF4});

        // Fill the FIFO while the device is stalled
        for (int b = 1; b <= 6; b++) put(8'(b));
        chk("fifo_full", full, 1);
        chk("fifo_level", level, 4);
        for (int b = 1; b <= 5; b++) begin
            dev_xfer(1'b0, 12, cap, ok);
            chk("fifo_order", {ok, cap[7:0]}, {1'b1, 8'(b)});
        end
        repeat (50) @(negedge clk);
        chk("fifo_drained", {level, tx_idle}, {3'd0, 1'b1});

        // A short clock glitch in START must not advance the frame
        put(8'h01);
        w = 0;
        while (!ps2d_oe && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (20) @(negedge clk);
        r_devc = 1'b0;
        #50;
        r_devc = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_hold", {ps2d_oe, ps2c_oe}, 2'b10);
        dev_xfer(1'b0, 12, cap, ok);
        chk("glitch_data", {ok, cap[7:0]}, {1'b1, 8'h01});

        // Reset in the middle of DATA
        d0 = n_done;
        put(8'h0F);
        dev_xfer(1'b0, 5, cap, ok);
        chk("mid_bits", {ok, cap[3:0]}, {1'b1, 4'hF});
        chk("mid_d_oe", ps2d_oe, 1);
        put(8'hAA);
        chk("mid_level", level, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_oe", {ps2c_oe, ps2d_oe}, 0);
        chk("rst_mid_level", level, 0);
        chk("rst_mid_idle", tx_idle, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_rst_quiet", {tx_idle, ps2c_oe, 32'(n_done - d0)}, {1'b1, 1'b0, 32'd0});

`ifdef PS2_TX_TIMEOUT_EN
        put(8'h33);
        w = 0;
        while (!(ps2d_oe && !ps2c_oe) && w < 200) begin
            @(negedge clk);
            w++;
        end
        cnt = 0;
        while (!timeout_err && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        chk("tmo_delay", cnt, TMO);
        chk("tmo_release", {ps2c_oe, ps2d_oe, tx_idle}, 3'b001);
        repeat (5) @(negedge clk);
        chk("tmo_count", n_tmo, 1);
`else
        chk("tmo_count", n_tmo, 0);
`endif
        chk("oe_overlap", n_both, 0);
        chk("pulse_width", n_long, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_tx_queue.md
PS2_TX_QUEUE -- requirements
Module: ps2_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter RTS_CYCLES, default 8192, clk cycles the clock line is held low for request-to-send.
REQ-003 SHALL have parameter FILTER_LEN, default 8, ps2c glitch-filter length in clk cycles.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 131072, clk cycles allowed from START entry to ACK completion.
REQ-005 SHALL have ports in this order: clk in 1 system clock; reset in 1 asynchronous active-high reset.
REQ-006 SHALL have wr_ps2 in 1 write strobe; din in 8 command byte; full out 1 FIFO full; level out $clog2(DEPTH)+1 FIFO occupancy.
REQ-007 SHALL have rx_idle in 1 receiver idle; ps2c_in in 1 raw clock line; ps2d_in in 1 raw data line.
REQ-008 SHALL have ps2c_oe out 1 and ps2d_oe out 1, each high = pull line low, low = release.
REQ-009 SHALL have tx_idle out 1; tx_done_tick out 1; ack_err out 1 (pulse); timeout_err out 1 (pulse).

Function
REQ-010 SHALL accept din when wr_ps2=1 and full=0; a write while full is discarded, FIFO unchanged.
REQ-011 SHALL filter ps2c: filtered value goes 1 after FILTER_LEN consecutive 1 samples, 0 after FILTER_LEN consecutive 0 samples, else holds; fall_edge = filtered 1->0.
REQ-012 SHALL synchronise ps2d_in through two flops before sampling.
REQ-013 SHALL implement states IDLE, WAITR, RTS, START, DATA, STOP, ACK.
REQ-014 IDLE: tx_idle=1; if FIFO non-empty, pop head, load shift reg {odd parity=~^byte, byte}, go WAITR next cycle.
REQ-015 WAITR: hold until rx_idle=1, then load RTS counter with RTS_CYCLES-1, go RTS.
REQ-016 RTS: ps2c_oe=1 for exactly RTS_CYCLES cycles, then go START.
REQ-017 START: ps2c_oe=0, ps2d_oe=1 (start bit 0); on fall_edge load bit count 8, go DATA.
REQ-018 DATA: ps2d_oe=~shift[0]; on fall_edge shift right; after 9th fall_edge (LSB first, parity last) go STOP.
REQ-019 STOP: both oe=0; on fall_edge go ACK.
REQ-020 ACK: on fall_edge sample synced ps2d; 0 -> tx_done_tick; 1 -> tx_done_tick and ack_err both pulse; go IDLE.
REQ-021 Latency: wr_ps2 into empty FIFO while IDLE with rx_idle=1 -> ps2c_oe rises 3 cycles later.
REQ-022 All pulse outputs SHALL be single-cycle; tx_idle=0 in every state except IDLE.
REQ-023 Simultaneous write and pop SHALL both take effect; level unchanged; full evaluated before the pop.
REQ-024 ps2c_oe and ps2d_oe SHALL never both be 1.

Reset
REQ-025 reset SHALL force IDLE, empty FIFO, level=0, full=0, tx_idle=1, both oe=0, all pulses 0, filter state 0.
REQ-026 Reset mid-transfer SHALL release both lines on the reset edge and discard the in-flight byte.

Configuration
REQ-027 With PS2_TX_TIMEOUT_EN defined: counter starts at START entry; reaching TIMEOUT_CYCLES before ACK completion pulses timeout_err, releases lines, drops byte, goes IDLE.
REQ-028 Without PS2_TX_TIMEOUT_EN: no counter is built, timeout_err is tied 0, states wait on the device indefinitely.

Structure
REQ-029 Package ps2_pkg SHALL hold the state enum, parity function and default parameter constants.
REQ-030 Sub-module ps2_clk_filter (FILTER_LEN param; ps2c_in -> filtered, fall_edge) SHALL be instantiated once.

Verification
REQ-031 RTS_CYCLES=16; write 0x55, device model clocks, acks 0 -> data bits 1,0,1,0,1,0,1,0, parity 1, tx_done_tick=1, ack_err=0.
REQ-032 Write 0x00, device acks 1 -> parity 1, tx_done_tick and ack_err pulse together.
REQ-033 rx_idle=0 held, write 0xF4 -> stays WAITR, ps2c_oe=0; rx_idle=1 -> 16 cycles ps2c_oe=1.
REQ-034 DEPTH=4, device stalled, write 0x01..0x06 -> 0x01 in flight, 0x02..0x05 queued, full=1, 0x06 dropped; bytes emitted in order.
REQ-035 PS2_TX_TIMEOUT_EN, TIMEOUT_CYCLES=200, device never clocks -> timeout_err pulse 200 cycles after START entry, oe both 0, tx_idle=1.
REQ-036 Assert reset in DATA after 4 bits -> next edge oe both 0, level=0, tx_idle=1; 50 ns glitch on ps2c never produces fall_edge.
